// File: rtl/factor_search_if.sv
// Request/result bus between the factor search sequencer, its host and the
// combinational factor checker.
interface factor_search_if #(
  parameter int FW = 4,
  parameter int PW = 8,
  parameter int CW = 8
);
  logic          start;
  logic          abort;
  logic [PW-1:0] target;
  logic [FW-1:0] cand1;
  logic [FW-1:0] cand2;
  logic [PW-1:0] cand_tgt;
  logic          check_ok;
  logic          busy;
  logic          done;
  logic          found;
  logic [FW-1:0] f1;
  logic [FW-1:0] f2;
  logic [CW-1:0] checks;

  // Handshake: start is a level sampled on the clock edge and is accepted only
  // while the sequencer is idle; done is a one-cycle pulse whose results in
  // found/f1/f2/checks stay valid until the next accepted start. check_ok must
  // answer the cand1/cand2/cand_tgt values presented in the same cycle.
  modport slave (
    input  start, abort, target, check_ok,
    output cand1, cand2, cand_tgt, busy, done, found, f1, f2, checks
  );

  modport master (
    output start, abort, target, check_ok,
    input  cand1, cand2, cand_tgt, busy, done, found, f1, f2, checks
  );
endinterface

// File: rtl/factor_search_ctrl.sv
// Walks unordered candidate factor pairs (2 <= f1 <= f2) through an external
// combinational checker, one pair per cycle, stopping on the first hit.
module factor_search_ctrl #(
  parameter int FW = 4,
  parameter int PW = 8,
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  factor_search_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [FW-1:0] MAX_F = '1;
  localparam logic [FW-1:0] MIN_F = FW'(2);
  localparam int            SQW   = PW + 2;

  state_e        state_q, state_d;
  logic [FW-1:0] cand1_q, cand1_d;
  logic [FW-1:0] cand2_q, cand2_d;
  logic [PW-1:0] tgt_q, tgt_d;
  logic          found_q, found_d;
  logic [FW-1:0] f1_q, f1_d;
  logic [FW-1:0] f2_q, f2_d;
  logic [CW-1:0] checks_q, checks_d;

  logic [FW:0]    next_row;
  logic [SQW-1:0] next_sq;
  logic           row_pruned;

  // A new row f1+1 can only hold a factor pair if (f1+1)^2 <= target.
  assign next_row   = {1'b0, cand1_q} + (FW+1)'(1);
  assign next_sq    = SQW'(next_row) * SQW'(next_row);
  assign row_pruned = (cand1_q == MAX_F) || (next_sq > SQW'(tgt_q));

  always_comb begin
    state_d  = state_q;
    cand1_d  = cand1_q;
    cand2_d  = cand2_q;
    tgt_d    = tgt_q;
    found_d  = found_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    checks_d = checks_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tgt_d    = bus.target;
          cand1_d  = MIN_F;
          cand2_d  = MIN_F;
          checks_d = '0;
          found_d  = 1'b0;
          f1_d     = '0;
          f2_d     = '0;
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        checks_d = checks_q + CW'(1);
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.check_ok) begin
          found_d = 1'b1;
          f1_d    = cand1_q;
          f2_d    = cand2_q;
          state_d = S_DONE;
        end else if (cand2_q != MAX_F) begin
          cand2_d = cand2_q + FW'(1);
        end else if (row_pruned) begin
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          cand1_d = cand1_q + FW'(1);
          cand2_d = cand1_q + FW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand1_q  <= '0;
      cand2_q  <= '0;
      tgt_q    <= '0;
      found_q  <= 1'b0;
      f1_q     <= '0;
      f2_q     <= '0;
      checks_q <= '0;
    end else begin
      state_q  <= state_d;
      cand1_q  <= cand1_d;
      cand2_q  <= cand2_d;
      tgt_q    <= tgt_d;
      found_q  <= found_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      checks_q <= checks_d;
    end
  end

  assign bus.cand1    = cand1_q;
  assign bus.cand2    = cand2_q;
  assign bus.cand_tgt = tgt_q;
  assign bus.busy     = (state_q == S_SEARCH);
  assign bus.done     = (state_q == S_DONE);
  assign bus.found    = found_q;
  assign bus.f1       = f1_q;
  assign bus.f2       = f2_q;
  assign bus.checks   = checks_q;
  assign dbg_state_o  = state_q;

endmodule
